// File: rtl/vga_bitgen.sv
// Pixel generator behind the VGA timing generator: border, checkerboard background
// and a bouncing box, with the syncs delayed one cycle to stay aligned with rgb.
module vga_bitgen #(
    parameter int         H_START   = 144,
    parameter int         V_START   = 0,
    parameter int         H_ACTIVE  = 640,
    parameter int         V_ACTIVE  = 480,
    parameter int         BOX_W     = 32,
    parameter int         BOX_X0    = 100,
    parameter int         BOX_Y0    = 100,
    parameter int         VS_POL    = 1,
    parameter logic [7:0] BOX_COLOR = 8'hE0,
    parameter logic [7:0] BG_A      = 8'h03,
    parameter logic [7:0] BG_B      = 8'h00
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       bright,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       move_en,
    input  logic [2:0] speed,
    output logic [7:0] rgb,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [7:0] frame_cnt
);

    localparam logic       VS_ACT = (VS_POL != 0);
    localparam logic [9:0] X_LIM  = 10'(H_ACTIVE - BOX_W);
    localparam logic [9:0] Y_LIM  = 10'(V_ACTIVE - BOX_W);
    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    logic [7:0] rgb_q, rgb_d;
    logic       hsync_q, vsync_q;
    logic [7:0] frame_cnt_q;
    logic [9:0] box_x_q, box_y_q;
    logic       dx_q, dy_q;
    logic       vs_prev_q;
    logic       armed_q;

    logic [9:0]  x, y;
    logic [10:0] vdiff;
    logic        visible, in_box, border, upd;
    logic [10:0] x_step, y_step;

    // Returns {dir, pos}; 11-bit sums so pos+speed never wraps before the limit compare.
    function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic dir,
                                              input logic [2:0] spd, input logic [9:0] lim);
        logic [10:0] sum;
        sum = {1'b0, pos} + {8'b0, spd};
        if (dir) begin
            if (sum >= {1'b0, lim}) return {1'b0, lim};
            else                    return {1'b1, sum[9:0]};
        end else begin
            if ({1'b0, pos} <= {8'b0, spd}) return {1'b1, 10'd0};
            else                            return {1'b0, pos - {7'b0, spd}};
        end
    endfunction

    always_comb begin
        x       = hcount - 10'(H_START);
        y       = vcount - 10'(V_START);
        vdiff   = {1'b0, vcount} - 11'(V_START);
        visible = bright && (vdiff < 11'(V_ACTIVE));
        in_box  = ({1'b0, x} >= {1'b0, box_x_q}) && ({1'b0, x} < {1'b0, box_x_q} + 11'(BOX_W)) &&
                  ({1'b0, y} >= {1'b0, box_y_q}) && ({1'b0, y} < {1'b0, box_y_q} + 11'(BOX_W));
        border  = (x == 10'd0) || (x == X_LAST) || (y == 10'd0) || (y == Y_LAST);
        rgb_d   = 8'h00;
        if (!visible)    rgb_d = 8'h00;
        else if (in_box) rgb_d = BOX_COLOR;
        else if (border) rgb_d = 8'hFF;
        else             rgb_d = (x[5] ^ y[5]) ? BG_A : BG_B;
    end

    // armed_q requires an inactive vsync sample after reset, so a vsync held active
    // across reset release is not mistaken for a new frame edge.
    assign upd    = armed_q && (vs_prev_q != VS_ACT) && (vsync_in == VS_ACT);
    assign x_step = axis_step(box_x_q, dx_q, speed, X_LIM);
    assign y_step = axis_step(box_y_q, dy_q, speed, Y_LIM);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            rgb_q       <= 8'h00;
            hsync_q     <= 1'b1;
            vsync_q     <= !VS_ACT;
            frame_cnt_q <= 8'd0;
            box_x_q     <= 10'(BOX_X0);
            box_y_q     <= 10'(BOX_Y0);
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            vs_prev_q   <= !VS_ACT;
            armed_q     <= 1'b0;
        end else begin
            rgb_q     <= rgb_d;
            hsync_q   <= hsync_in;
            vsync_q   <= vsync_in;
            vs_prev_q <= vsync_in;
            if (vsync_in != VS_ACT) armed_q <= 1'b1;
            if (upd) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
                if (move_en && (speed != 3'd0)) begin
                    dx_q    <= x_step[10];
                    box_x_q <= x_step[9:0];
                    dy_q    <= y_step[10];
                    box_y_q <= y_step[9:0];
                end
            end
        end
    end

    assign rgb       = rgb_q;
    assign hsync_out = hsync_q;
    assign vsync_out = vsync_q;
    assign frame_cnt = frame_cnt_q;

endmodule
